sprite_motion_ctrl: RTL

Frame-rate controller for the bouncing-image datapath. Once per frame it computes and commits the sprite's top-left position, reflecting off the active-area edges. It also debounces the user button and cycles the displayed image index. Position and image changes are committed atomically at a frame boundary, so the pixel datapath never tears mid-frame.

---
 rtl/sprite_motion_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
// Once per frame, moves the sprite's top-left corner by STEP on each axis and
// reflects it off the active-area edges. The user button is debounced, and
// each press advances the displayed image index. The new position and image
// change together at the COMMIT step, so the pixel datapath never sees a
// half-updated sprite.
//
// Ports:
//   clk_25_175  in   pixel clock (the only clock)
//   rst         in   asynchronous, active-high reset
//   frame_start in   single-cycle pulse at the start of vertical blanking
//   btn_n       in   raw button, active-low, asynchronous to the clock
//   sprite_x    out  committed sprite left column
//   sprite_y    out  committed sprite top line
//   image_sel   out  committed image index
//   busy        out  high while an update is in progress
//   move_done   out  one-cycle pulse in the cycle the commit takes place
//
// state   | meaning
// IDLE    | waiting for frame_start
// MOVE_X  | compute next x into the shadow register nx, update dx
// MOVE_Y  | compute next y into the shadow register ny, update dy
// COMMIT  | copy nx/ny to the outputs and apply any pending image change

module sprite_motion_ctrl #(
  parameter int IMAGE_SELECT    = 0,
  parameter int NUM_IMAGES      = 4,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int SPRITE_W        = 64,
  parameter int SPRITE_H        = 64,
  parameter int STEP            = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                          clk_25_175,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic                          btn_n,
  output logic [9:0]                    sprite_x,
  output logic [9:0]                    sprite_y,
  output logic [$clog2(NUM_IMAGES)-1:0] image_sel,
  output logic                          busy,
  output logic                          move_done
);

  localparam int IW = $clog2(NUM_IMAGES);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [10:0]   XMAX     = 11'(H_ACTIVE - SPRITE_W);
  localparam logic [10:0]   YMAX     = 11'(V_ACTIVE - SPRITE_H);
  localparam logic [10:0]   STEP_W   = 11'(STEP);
  localparam logic [IW-1:0] IMG_LAST = IW'(NUM_IMAGES - 1);
  localparam logic [IW-1:0] IMG_INIT = IW'(IMAGE_SELECT);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, COMMIT} state_t;

  state_t state, state_nx;

  logic       dx, dy;
  logic [9:0] nx, ny;

  logic          sync1, sync2, db_level, db_prev, pending;
  logic [CW-1:0] db_cnt;
  logic          press;

  // Both step directions are computed in 11 bits so that x+STEP cannot wrap
  // before it is clamped against the limit.
  logic [10:0] x_ext, x_up, x_dn, y_ext, y_up, y_dn;

  always_comb begin
    x_ext = {1'b0, sprite_x};
    y_ext = {1'b0, sprite_y};
    x_up  = (x_ext + STEP_W >= XMAX) ? XMAX : x_ext + STEP_W;
    y_up  = (y_ext + STEP_W >= YMAX) ? YMAX : y_ext + STEP_W;
    x_dn  = (x_ext <= STEP_W) ? 11'd0 : x_ext - STEP_W;
    y_dn  = (y_ext <= STEP_W) ? 11'd0 : y_ext - STEP_W;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_start) state_nx = MOVE_X;
      MOVE_X:  state_nx = MOVE_Y;
      MOVE_Y:  state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_25_175 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      move_done <= 1'b0;
    end else begin
      state     <= state_nx;
      busy      <= (state_nx != IDLE);
      move_done <= (state_nx == COMMIT);
    end
  end

  always_ff @(posedge clk_25_175 or posedge rst) begin
    if (rst) begin
      dx       <= 1'b1;
      dy       <= 1'b1;
      nx       <= '0;
      ny       <= '0;
      sprite_x <= '0;
      sprite_y <= '0;
    end else begin
      case (state)
        MOVE_X: begin
          if (dx) begin
            nx <= x_up[9:0];
            if (x_up == XMAX) dx <= 1'b0;
          end else begin
            nx <= x_dn[9:0];
            if (x_dn == 11'd0) dx <= 1'b1;
          end
        end
        MOVE_Y: begin
          if (dy) begin
            ny <= y_up[9:0];
            if (y_up == YMAX) dy <= 1'b0;
          end else begin
            ny <= y_dn[9:0];
            if (y_dn == 11'd0) dy <= 1'b1;
          end
        end
        COMMIT: begin
          sprite_x <= nx;
          sprite_y <= ny;
        end
        default: ;
      endcase
    end
  end

  // Button: two-flop synchronizer, then a counter that must see
  // DEBOUNCE_CYCLES consecutive disagreeing samples before the level flips.
  always_ff @(posedge clk_25_175 or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      db_level <= 1'b1;
      db_prev  <= 1'b1;
      db_cnt   <= '0;
    end else begin
      sync1   <= btn_n;
      sync2   <= sync1;
      db_prev <= db_level;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = db_prev & ~db_level;

  // A press that lands in the COMMIT cycle re-arms the flag for the next frame.
  always_ff @(posedge clk_25_175 or posedge rst) begin
    if (rst) begin
      pending   <= 1'b0;
      image_sel <= IMG_INIT;
    end else if (state == COMMIT) begin
      if (pending) image_sel <= (image_sel == IMG_LAST) ? '0 : image_sel + 1'b1;
      pending <= press;
    end else begin
      pending <= pending | press;
    end
  end

endmodule
